// File: rtl/xpb_pkg.sv
// Shared types and default widths for the xpb accumulation sequencer.
package xpb_pkg;

  localparam int SEG_W_DEF  = 5;
  localparam int WORD_W_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xpb_state_e;

endpackage

// File: rtl/xpb_inflight_pipe.sv
// Tracks table reads in flight: a LAT-deep valid shift register fed by the issue strobe.
module xpb_inflight_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_rd,
  output logic o_vld,
  output logic o_pend
);

  // Every stage except the output one; these still hold reads after the next edge.
  localparam logic [LAT-1:0] PEND_MASK = {LAT{1'b1}} >> 1;

  logic [LAT-1:0] r_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld <= LAT'({r_vld, i_rd});
    end
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_pend = |(r_vld & PEND_MASK);

endmodule

// File: rtl/xpb_accum_seq.sv
// Issues one operand digit per cycle to the xpb table bank and sums the returned residues.
module xpb_accum_seq
  import xpb_pkg::*;
#(
  parameter int  WORD_W  = WORD_W_DEF,
  parameter int  SEG_W   = SEG_W_DEF,
  parameter int  NUM_SEG = 8,
  parameter int  LAT     = 1,
  localparam int ACC_W   = WORD_W + $clog2(NUM_SEG),
  localparam int SEL_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SEG*SEG_W-1:0] in_upper,
  output logic [SEL_W-1:0]         xpb_sel,
  output logic [SEG_W-1:0]         xpb_idx,
  output logic                     xpb_rd,
  input  logic [WORD_W-1:0]        xpb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and data until that edge, and ready never depends on valid.

  xpb_state_e               r_state;
  logic [NUM_SEG*SEG_W-1:0] r_upper;
  logic [SEL_W-1:0]         r_cnt;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         w_acc_next;
  logic [SEG_W-1:0]         w_digit;
  logic                     w_pipe_vld;
  logic                     w_pipe_pend;

  xpb_inflight_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_rd   (xpb_rd),
    .o_vld  (w_pipe_vld),
    .o_pend (w_pipe_pend)
  );

  assign w_digit    = r_upper[r_cnt*SEG_W +: SEG_W];
  assign w_acc_next = r_acc + (w_pipe_vld ? ACC_W'(xpb_data) : '0);
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_upper   <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      in_ready  <= 1'b1;
      xpb_rd    <= 1'b0;
      xpb_sel   <= '0;
      xpb_idx   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (w_pipe_vld) begin
        r_acc <= w_acc_next;
      end
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_upper  <= in_upper;
            r_acc    <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          xpb_rd  <= 1'b1;
          xpb_sel <= r_cnt;
          xpb_idx <= w_digit;
          if (r_cnt == SEL_W'(NUM_SEG - 1)) begin
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          xpb_rd <= 1'b0;
          // Nothing issued this cycle and nothing left behind the output stage:
          // this edge folds in the last residue, so capture the sum including it.
          if (!xpb_rd && !w_pipe_pend) begin
            out_sum   <= w_acc_next;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Self-checking bench for xpb_accum_seq: table model, operand/sum scoreboard, directed and random ops.
module tb_xpb_accum_seq;

  localparam int WORD_W  = 1024;
  localparam int SEG_W   = 5;
  localparam int NUM_SEG = 8;
  localparam int LAT     = 1;
  localparam int ACC_W   = WORD_W + 3;
  localparam int SEL_W   = 3;
  localparam int OP_W    = NUM_SEG * SEG_W;

  typedef logic [ACC_W-1:0] acc_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_upper;
  logic [SEL_W-1:0]  xpb_sel;
  logic [SEG_W-1:0]  xpb_idx;
  logic              xpb_rd;
  logic [WORD_W-1:0] xpb_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              busy;
  logic [1:0]        dbg_state;

  xpb_accum_seq #(
    .WORD_W  (WORD_W),
    .SEG_W   (SEG_W),
    .NUM_SEG (NUM_SEG),
    .LAT     (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_upper  (in_upper),
    .xpb_sel   (xpb_sel),
    .xpb_idx   (xpb_idx),
    .xpb_rd    (xpb_rd),
    .xpb_data  (xpb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input acc_t act, input acc_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s timeout", nm);
  endtask

  // ---------------- table bank model ----------------
  int tab_mode;  // 0: (sel+1)*idx, 1: all ones, 2: random table
  logic [WORD_W-1:0] rtab [NUM_SEG][32];

  function automatic logic [WORD_W-1:0] tbl_val(input int sel, input int idx);
    if (tab_mode == 1) return '1;
    if (tab_mode == 2) return rtab[sel][idx];
    return WORD_W'((sel + 1) * idx);
  endfunction

  always @(posedge clk) begin
    if (xpb_rd) xpb_data <= tbl_val(int'(xpb_sel), int'(xpb_idx));
  end

  function automatic acc_t op_sum(input logic [OP_W-1:0] op);
    acc_t s = '0;
    for (int k = 0; k < NUM_SEG; k++) s += acc_t'(tbl_val(k, int'(op[k*SEG_W +: SEG_W])));
    return s;
  endfunction

  function automatic logic [OP_W-1:0] rep_op(input int d);
    logic [OP_W-1:0] op = '0;
    for (int k = 0; k < NUM_SEG; k++) op[k*SEG_W +: SEG_W] = SEG_W'(d);
    return op;
  endfunction

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] op = '0;
    for (int k = 0; k < NUM_SEG; k++) op[k*SEG_W +: SEG_W] = SEG_W'($urandom_range(0, 31));
    return op;
  endfunction

  // ---------------- out_ready driver ----------------
  int   ready_mode;   // 0: always high, 1: random, 2: follow ready_force
  logic ready_force;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      out_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2) out_ready = ready_force;
      else                      out_ready = 1'b1;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  acc_t exp_q[$];
  int   rs_q[$];
  int   ri_q[$];
  int   sel_log[$];
  int   off_log[$];
  int   acc_hist[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rd_n = 0;
  int   last_out_lat = 0;
  bit   active = 0;
  bit   seen_valid = 0;
  bit   prev_hold = 0;
  acc_t prev_sum = '0;
  acc_t last_sum = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete(); rs_q.delete(); ri_q.delete();
      active = 0; seen_valid = 0; prev_hold = 0;
    end else begin
      chk("busy", acc_t'(busy), acc_t'(active));
      chk("in_ready", acc_t'(in_ready), acc_t'(!active));
      if (xpb_rd) begin
        if (rs_q.size() == 0 || out_valid) begin
          fail_now("unexpected_read");
        end else begin
          chk("rd_sel", acc_t'(xpb_sel), acc_t'(rs_q.pop_front()));
          chk("rd_idx", acc_t'(xpb_idx), acc_t'(ri_q.pop_front()));
          chk("rd_cycle", acc_t'(cyc - acc_cyc), acc_t'(rd_n + 1));
          sel_log.push_back(int'(xpb_sel));
          off_log.push_back(cyc - acc_cyc);
          rd_n++;
        end
      end
      if (prev_hold) begin
        chk("hold_valid", acc_t'(out_valid), acc_t'(1));
        chk("hold_sum", out_sum, prev_sum);
      end
      if (out_valid && !seen_valid) begin
        seen_valid   = 1;
        last_out_lat = cyc - acc_cyc;
        chk("out_latency", acc_t'(last_out_lat), acc_t'(NUM_SEG + LAT + 1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else chk("out_sum", out_sum, exp_q.pop_front());
        last_sum   = out_sum;
        active     = 0;
        seen_valid = 0;
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      if (in_valid && in_ready) begin
        exp_q.push_back(op_sum(in_upper));
        for (int k = 0; k < NUM_SEG; k++) begin
          rs_q.push_back(k);
          ri_q.push_back(int'(in_upper[k*SEG_W +: SEG_W]));
        end
        sel_log.delete();
        off_log.delete();
        active  = 1;
        acc_cyc = cyc + 1;
        rd_n    = 0;
        acc_hist.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic [OP_W-1:0] op);
    bit ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_upper = op;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) fail_now("send_op");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy && !out_valid && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("wait_idle");
  endtask

  initial begin
    #500000;
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // ---------------- tests ----------------
  initial begin
    acc_t t3_exp;
    int   h0;
    logic [OP_W-1:0] b2b [3];
    bit   ok;

    reset = 1'b1; in_valid = 1'b0; in_upper = '0;
    ready_mode = 0; ready_force = 1'b1; tab_mode = 0;
    xpb_data = '0;
    for (int s = 0; s < NUM_SEG; s++)
      for (int i = 0; i < 32; i++)
        for (int w = 0; w < WORD_W / 32; w++) rtab[s][i][w*32 +: 32] = $urandom();

    repeat (3) @(negedge clk);
    chk("rst_in_ready", acc_t'(in_ready), acc_t'(1));
    chk("rst_xpb_rd", acc_t'(xpb_rd), acc_t'(0));
    chk("rst_xpb_sel", acc_t'(xpb_sel), acc_t'(0));
    chk("rst_xpb_idx", acc_t'(xpb_idx), acc_t'(0));
    chk("rst_out_valid", acc_t'(out_valid), acc_t'(0));
    chk("rst_out_sum", out_sum, acc_t'(0));
    chk("rst_busy", acc_t'(busy), acc_t'(0));
    chk("rst_state", acc_t'(dbg_state), acc_t'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // T1: all ones -> 36, latency 10, selects 0..7 on cycles 1..8
    send_op(rep_op(1));
    wait_idle();
    chk("t1_sum", last_sum, acc_t'(36));
    chk("t1_latency", acc_t'(last_out_lat), acc_t'(10));
    chk("t1_nreads", acc_t'(sel_log.size()), acc_t'(8));
    for (int k = 0; k < sel_log.size() && k < 8; k++) begin
      chk("t1_sel_seq", acc_t'(sel_log[k]), acc_t'(k));
      chk("t1_rd_cycle", acc_t'(off_log[k]), acc_t'(k + 1));
    end

    // T2: all 31 -> 1116; all zero -> 0 with 8 reads still issued
    send_op(rep_op(31));
    wait_idle();
    chk("t2_sum31", last_sum, acc_t'(1116));
    send_op(rep_op(0));
    wait_idle();
    chk("t2_sum0", last_sum, acc_t'(0));
    chk("t2_zero_reads", acc_t'(rd_n), acc_t'(8));

    // T3: every read returns 2^1024-1 -> 8*(2^1024-1) in 1027 bits
    tab_mode = 1;
    send_op(rep_op(7));
    wait_idle();
    t3_exp = {{WORD_W{1'b1}}, 3'b000};
    chk("t3_wide_sum", last_sum, t3_exp);
    tab_mode = 0;

    // T4: backpressure in DONE for 5 cycles with a stray in_valid pulse
    ready_mode = 2;
    ready_force = 1'b0;
    h0 = acc_hist.size();
    send_op(rep_op(3));
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("t4_wait_valid");
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_upper = rep_op(9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_valid_held", acc_t'(out_valid), acc_t'(1));
    chk("t4_sum_held", out_sum, acc_t'(108));
    chk("t4_no_rd", acc_t'(xpb_rd), acc_t'(0));
    ready_force = 1'b1;
    wait_idle();
    chk("t4_sum", last_sum, acc_t'(108));
    chk("t4_accepts", acc_t'(acc_hist.size() - h0), acc_t'(1));
    ready_mode = 0;

    // T5: reset in cycle 4 of ISSUE, then all-2 operand -> 72
    send_op(rep_op(5));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_in_ready", acc_t'(in_ready), acc_t'(1));
    chk("t5_xpb_rd", acc_t'(xpb_rd), acc_t'(0));
    chk("t5_xpb_sel", acc_t'(xpb_sel), acc_t'(0));
    chk("t5_xpb_idx", acc_t'(xpb_idx), acc_t'(0));
    chk("t5_out_valid", acc_t'(out_valid), acc_t'(0));
    chk("t5_out_sum", out_sum, acc_t'(0));
    chk("t5_busy", acc_t'(busy), acc_t'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_op(rep_op(2));
    wait_idle();
    chk("t5_sum", last_sum, acc_t'(72));

    // T6: back-to-back with in_valid and out_ready held high
    tab_mode = 2;
    for (int i = 0; i < 3; i++) b2b[i] = rand_op();
    h0 = acc_hist.size();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_upper = b2b[0];
    for (int i = 0; i < 3; i++) begin
      ok = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) fail_now("t6_accept");
      @(posedge clk); #1;
      if (i < 2) in_upper = b2b[i + 1];
      else       in_valid = 1'b0;
    end
    wait_idle();
    chk("t6_accepts", acc_t'(acc_hist.size() - h0), acc_t'(3));
    for (int i = h0 + 1; i < acc_hist.size(); i++)
      chk("t6_period", acc_t'(acc_hist[i] - acc_hist[i-1]), acc_t'(12));

    // Random operands, random table contents, random backpressure and gaps
    ready_mode = 1;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_op(rand_op());
    end
    wait_idle();
    ready_mode = 0;

    chk("final_queue_empty", acc_t'(exp_q.size()), acc_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
